// File: rtl/seq_sub_16_bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_sub_16_bit_if
//  Description : Request/result bundle for the sequential 16-bit subtractor.
//                master : issues start/a/b, observes busy/done/result flags
//                slave  : the subtractor itself
//  Signals     : start    - request, honoured only when the block is not busy
//                a, b     - minuend / subtrahend, sampled on the accepting edge
//                busy     - operation in progress
//                done     - one-cycle completion pulse
//                diff     - a - b modulo 2^16
//                borrow   - unsigned a < b
//                overflow - signed overflow of a - b
//                zero     - diff == 0
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_sub_16_bit_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow, zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_sub_16_bit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_sub_16_bit
//  Description : Sequential 16-bit subtractor. Computes a - b as a + ~b + 1,
//                one 4-bit carry-lookahead slice per clock (four slices).
//                Accept edge E0, slices at E1..E4, done pulses the cycle
//                after E4. A request seen in the DONE cycle is accepted,
//                giving a 5-cycle issue interval.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - seq_sub_16_bit_if.slave (start/a/b in,
//                        busy/done/diff/borrow/overflow/zero out)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_sub_16_bit (
    input  wire                   clk,
    input  wire                   rst_n,
    seq_sub_16_bit_if.slave       bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_k;
    logic        r_c;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [11:0] r_part;     // slices 0..2; slice 3 goes straight to r_diff
    logic [15:0] r_diff;
    logic        r_borrow;
    logic        r_overflow;
    logic        r_zero;

    logic [3:0]  w_x;
    logic [3:0]  w_y;
    logic [3:0]  w_p;
    logic [3:0]  w_g;
    logic [4:0]  w_cy;
    logic [3:0]  w_sum;
    logic [15:0] w_result;
    logic        w_accept;

    // Select the current slice of the latched operands; b is inverted so the
    // adder computes a + ~b + c with c seeded to 1.
    always_comb begin
        w_x = r_a[3:0];
        w_y = ~r_b[3:0];
        case (r_k)
            2'd1:    begin w_x = r_a[7:4];   w_y = ~r_b[7:4];   end
            2'd2:    begin w_x = r_a[11:8];  w_y = ~r_b[11:8];  end
            2'd3:    begin w_x = r_a[15:12]; w_y = ~r_b[15:12]; end
            default: begin w_x = r_a[3:0];   w_y = ~r_b[3:0];   end
        endcase
    end

    // 4-bit carry lookahead: every carry is a flat function of p, g and c0.
    assign w_p     = w_x ^ w_y;
    assign w_g     = w_x & w_y;
    assign w_cy[0] = r_c;
    assign w_cy[1] = w_g[0] | (w_p[0] & w_cy[0]);
    assign w_cy[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cy[0]);
    assign w_cy[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_cy[0]);
    assign w_cy[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cy[0]);
    assign w_sum   = w_p ^ w_cy[3:0];

    // Only meaningful in the last RUN cycle (k == 3).
    assign w_result = {w_sum, r_part};

    assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_k        <= 2'd0;
            r_c        <= 1'b0;
            r_a        <= 16'h0000;
            r_b        <= 16'h0000;
            r_part     <= 12'h000;
            r_diff     <= 16'h0000;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_c     <= 1'b1;
                        r_k     <= 2'd0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    case (r_k)
                        2'd0:    r_part[3:0]  <= w_sum;
                        2'd1:    r_part[7:4]  <= w_sum;
                        2'd2:    r_part[11:8] <= w_sum;
                        default: ;
                    endcase
                    r_c <= w_cy[4];
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        r_diff     <= w_result;
                        r_borrow   <= ~w_cy[4];
                        r_overflow <= (r_a[15] ^ r_b[15]) & (w_result[15] ^ r_a[15]);
                        r_zero     <= (w_result == 16'h0000);
                        r_state    <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (r_state == ST_RUN);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.diff     = r_diff;
    assign bus.borrow   = r_borrow;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;

endmodule

`default_nettype wire

// File: doc/seq_sub_16_bit.md
SEQ_SUB_16_BIT -- requirements
Module: seq_sub_16_bit

Interface
REQ-001 Parameters: none; width fixed at 16 bits, processed as four 4-bit slices.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled on rising clk when not busy.
REQ-005 a  input  16  minuend; sampled only on the accepting edge.
REQ-006 b  input  16  subtrahend; sampled only on the accepting edge.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  one-cycle pulse; result registers valid.
REQ-009 diff  output  16  registered result a - b, modulo 2^16.
REQ-010 borrow  output  1  high when a < b, unsigned.
REQ-011 overflow  output  1  high on signed (two's-complement) overflow of a - b.
REQ-012 zero  output  1  high when diff == 16'h0000.

Function
REQ-013 The block SHALL have an FSM with states IDLE, RUN and DONE, plus a 2-bit slice counter k.
REQ-014 IDLE: on start=1, the block SHALL latch a and b into internal operand registers, set carry register c=1, set k=0, and go to RUN.
REQ-015 IDLE with start=0: the block SHALL stay in IDLE.
REQ-016 RUN, each cycle: the block SHALL form slice k as a[4k+3:4k] + ~b[4k+3:4k] + c, using 4-bit carry-lookahead equations (p = x^y, g = x&y, c1..c4 by lookahead).
REQ-017 RUN, each cycle: the block SHALL store the 4-bit sum into a partial-result register, load c with c4, and increment k.
REQ-018 RUN with k==3: the block SHALL, on the same edge, load diff, borrow, overflow and zero from the completed result and go to DONE.
REQ-019 Latency: start accepted at edge E0; slices computed at E1..E4; done SHALL be high for exactly the cycle following E4.
REQ-020 borrow SHALL equal ~c4 of slice 3.
REQ-021 overflow SHALL equal (a[15] != b[15]) & (diff[15] != a[15]), using latched operands.
REQ-022 zero SHALL equal (diff == 0).
REQ-023 busy SHALL be high in RUN and low in IDLE and DONE.
REQ-024 DONE with start=1: the request SHALL be accepted exactly as from IDLE, giving back-to-back operation with a 5-cycle issue interval.
REQ-025 DONE with start=0: the block SHALL go to IDLE.
REQ-026 start while busy SHALL be ignored; changes on a/b after acceptance SHALL NOT affect the result.
REQ-027 diff, borrow, overflow and zero SHALL hold their last values until the next completion (E4 of the next operation).
REQ-028 Intermediate slice results SHALL NOT appear on diff.
REQ-029 done SHALL NOT assert except after a full 4-slice run.

Reset
REQ-030 rst_n=0 SHALL immediately force state to IDLE and k, c, operand and partial registers to 0.
REQ-031 rst_n=0 SHALL immediately force busy=0, done=0, diff=16'h0000, borrow=0, overflow=0 and zero=0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-033 After reset deasserts, the first edge with start=1 SHALL begin a fresh operation.

Verification
REQ-034 a=16'h1234, b=16'h0234 -> done 4 cycles after accept; diff=16'h1000, borrow=0, overflow=0, zero=0.
REQ-035 a=16'h0000, b=16'h0001 -> diff=16'hFFFF, borrow=1, overflow=0, zero=0; a=16'h8000, b=16'h0001 -> diff=16'h7FFF, borrow=0, overflow=1.
REQ-036 a=b=16'hA5A5 -> diff=16'h0000, zero=1, borrow=0, overflow=0; a=16'h7FFF, b=16'hFFFF -> diff=16'h8000, overflow=1, borrow=1.
REQ-037 start pulsed again in RUN with a=b=16'hFFFF, a/b changed after accept -> ignored; result matches first-accepted operands; single done pulse.
REQ-038 Back-to-back: start held high through DONE -> second operation accepted in the DONE cycle; second done exactly 5 cycles after the first.
REQ-039 rst_n low during RUN at k=2 -> all outputs 0 asynchronously, no done pulse; a new start after release gives a correct result.
REQ-040 Random check: 1000 random a/b pairs SHALL be compared against a reference model for diff, borrow, overflow and zero.
